mel_log_compress: RTL and testbench
===================================

# mel_log_compress

Log-compression stage directly downstream of the mel filter bank wrapper. It accepts one frame of 40 unsigned 16-bit mel band energies over a valid/ready handshake. It converts each band serially to a fixed-point base-2 logarithm using a leading-one detector plus linear (Mitchell) mantissa interpolation. It presents the 40 results as a parallel array to the next stage (DCT/MFCC).

## Interface
- `NBANDS`, default 40: bands per frame; the index counter is sized `$clog2(NBANDS)`.
- `IN_W`, default 16: input energy width; must be ≤ 16.
- `FRAC_W`, default 8: fraction bits of the output; the output format is unsigned Q8.8.
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `s_valid`, input, 1: upstream frame valid.
- `s_ready`, output, 1: block can accept a frame.
- `in[NBANDS]`, input, IN_W each: mel band energies, sampled on the accept edge.
- `m_valid`, output, 1: `out` holds a complete frame.
- `m_ready`, input, 1: downstream accepts the frame.
- `out[NBANDS]`, output, 16 each: log2 results in Q8.8, upper 4 integer bits always 0.

## Operation
- FSM states:
  - IDLE:
    - `s_ready`=1.
    - On `s_valid`&&`s_ready`, register all of `in` into a frame buffer, clear index k, and go to PROC.
  - PROC:
    - `s_ready`=0.
    - Each cycle, compute band k and write `out[k]`; increment k.
    - After k=NBANDS-1, go to DONE.
  - DONE:
    - `m_valid`=1; `s_ready`=0.
    - On `m_ready`, go to IDLE.
- Conversion for value x, with p = position of the leading one (0..15):
  - x=0: result 0x0000. This is defined, not an error.
  - Otherwise, integer part = p.
  - Fraction = the p bits below the leading one, left-aligned into FRAC_W bits.
    - If p > FRAC_W, truncate the extra low bits.
    - If p < FRAC_W, zero-pad on the right.
  - Result = {4'b0, p[3:0], frac[7:0]}.
- `s_valid` while not in IDLE is ignored. `in` is not sampled, and upstream must hold it.
- `out` entries are individually overwritten during PROC. `out` holds the last frame's values between frames.
- `out` is stable and complete for the entire time `m_valid`=1.

## Timing
- Reset values (asynchronous on `reset_n`=0):
  - state=IDLE, so `s_ready`=1.
  - `m_valid`=0.
  - k=0.
  - all `out`=0x0000.
  - frame buffer=0.
- Accept edge T, with `s_valid`&&`s_ready` high at T:
  - `s_ready` falls after T.
  - `out[k]` is written at edge T+1+k.
  - `m_valid` rises after edge T+NBANDS, i.e. it is visible in cycle T+41 by default.
- With `MEL_LOG_DB_EN`, one extra pipeline stage is added. `m_valid` rises one cycle later, at T+42.
- `m_valid` remains high until the first edge with `m_ready`=1. Both `m_valid` and `s_ready` change after that edge.
- `s_ready`=1 the cycle after the output handshake. There is no same-cycle output-to-input overlap.
- `m_ready` high before `m_valid` has no effect.
- `reset_n` asserted mid-PROC or in DONE:
  - The current frame is aborted and all outputs go to their reset values.
  - No partial `m_valid` is produced.

## Configuration
- `MEL_LOG_DB_EN` defined:
  - Each log2 result is scaled by 10·log10(2) ≈ 771/256.
  - out = (log2_q88 × 771) >> 8, truncated, still Q8.8 (max 0x302D).
  - The scaling adds one register stage, so latency is NBANDS+2.
- `MEL_LOG_DB_EN` undefined: raw log2 Q8.8, latency NBANDS+1, no multiplier.

## Test plan
- After reset release:
  - All `out`=0, `m_valid`=0, `s_ready`=1.
  - One frame with in[0..4] = {0, 1, 2, 3, 0x0300}, rest 0. Expect out[0..4] = {0x0000, 0x0000, 0x0100, 0x0180, 0x0980}, and `m_valid` at T+41.
- All bands 0xFFFF:
  - Every out = 0x0FFF.
  - With `MEL_LOG_DB_EN`: out[*] = 0x302D, and in=2 gives 0x0303, with `m_valid` at T+42.
- Backpressure and ignored input:
  - Hold `m_ready`=0 for 20 cycles after `m_valid`. `m_valid` and `out` stay constant and `s_ready` stays 0.
  - Toggle `s_valid` with new data during PROC. No effect on results.
- Reset mid-frame:
  - Assert `reset_n`=0 at T+20. All outputs are at reset values immediately.
  - A new frame after release produces correct results with no `m_valid` glitch.
- Back-to-back frames:
  - Raise `m_ready` at `m_valid`. `s_ready` returns the next cycle.
  - The second frame (ramp in[k]=k+1) yields out[k] = log2 per the rule, e.g. out[7]=0x0300, out[39]=0x0540.

Source files
------------

// File: rtl/mel_log_compress.sv
// mel_log_compress -- log2 compression of one mel frame.
//
// Accepts NBANDS unsigned band energies on a valid/ready handshake, converts
// them one band per cycle to an unsigned Q8.8 base-2 logarithm (leading-one
// position + linear Mitchell mantissa) and presents the whole frame in
// parallel until the downstream stage takes it.
//
// Optional feature macro: MEL_LOG_DB_EN
//   defined   -> each log2 result is scaled by 771/256 (~10*log10(2)), which
//                adds one register stage (frame latency NBANDS+2 edges)
//   undefined -> raw log2 Q8.8, latency NBANDS+1, no multiplier
//
// Ports
//   clk, reset_n      rising-edge clock, async active-low reset
//   s_valid/s_ready   input frame handshake; in[] sampled on the accept edge
//   in[NBANDS]        IN_W-bit band energies
//   m_valid/m_ready   output frame handshake
//   out[NBANDS]       16-bit Q8.8 log results, held between frames

// Single-band converter: {4'b0, p, frac} where p = leading-one position and
// frac = the bits below the leading one, left-aligned (truncated / zero-padded).
module mel_log2_conv #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8
) (
  input  logic [IN_W-1:0] x,
  output logic [15:0]     y
);
  logic [15:0] x16;
  logic [3:0]  p;

  always_comb begin
    x16 = 16'(x);
    p   = '0;
    for (int i = 0; i < 16; i++)
      if (x16[i]) p = 4'(i);
    // Shift the leading one up to bit 15; the next FRAC_W bits are the
    // mantissa. x=0 falls out naturally as 0x0000.
    y = 16'({p, FRAC_W'((x16 << (4'd15 - p)) >> (15 - FRAC_W))});
  end
endmodule

module mel_log_compress #(
  parameter int NBANDS = 40,
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NBANDS-1:0][IN_W-1:0]   in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NBANDS-1:0][15:0]       out
);
  localparam int KW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
`ifdef MEL_LOG_DB_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
  state_t state, state_nxt;

  logic [NBANDS-1:0][IN_W-1:0] fbuf;
  logic [KW-1:0]               k;
  logic                        issued;   // last band has entered the pipe
  logic                        issue;
  logic                        last0;
  logic [15:0]                 l2;

  // Stage 0 is the combinational conversion; stage STAGES writes out[].
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0]             last_pipe;
  logic [KW-1:0]               wr_idx;
  logic [15:0]                 wr_data;

  assign issue = (state == PROC) && !issued;
  assign last0 = (k == KW'(NBANDS-1));

  mel_log2_conv #(.IN_W(IN_W), .FRAC_W(FRAC_W)) u_conv (
    .x (fbuf[k]),
    .y (l2)
  );

`ifdef MEL_LOG_DB_EN
  logic          vld_q, last_q;
  logic [KW-1:0] idx_q;
  logic [15:0]   l2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      idx_q  <= '0;
      l2_q   <= '0;
    end else begin
      vld_q  <= issue;
      last_q <= last0;
      idx_q  <= k;
      l2_q   <= l2;
    end
  end

  assign vld_pipe  = {vld_q, issue};
  assign last_pipe = {last_q, last0};
  assign wr_idx    = idx_q;
  // x771 >> 8, truncated; max 0x0FFF -> 0x302D so 16 bits suffice.
  assign wr_data   = 16'((32'(l2_q) * 32'd771) >> 8);
`else
  assign vld_pipe  = issue;
  assign last_pipe = last0;
  assign wr_idx    = k;
  assign wr_data   = l2;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: PROC ends on the edge that writes the last band.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (s_valid) state_nxt = PROC;
      PROC: if (vld_pipe[STAGES] && last_pipe[STAGES]) state_nxt = DONE;
      DONE: if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_ready = (state == IDLE);
    m_valid = (state == DONE);
  end

  // Frame buffer, band index and result array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fbuf   <= '0;
      k      <= '0;
      issued <= 1'b0;
      out    <= '0;
    end else begin
      if (state == IDLE && s_valid) begin
        fbuf   <= in;
        k      <= '0;
        issued <= 1'b0;
      end else if (issue) begin
        if (last0) issued <= 1'b1;
        else       k      <= k + 1'b1;
      end
      if (vld_pipe[STAGES]) out[wr_idx] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mel_log_compress.sv
module tb_mel_log_compress;
  localparam int NB = 40;
`ifdef MEL_LOG_DB_EN
  localparam int LAT = NB + 1;
  localparam logic [15:0] EXP_FF = 16'h302D;
`else
  localparam int LAT = NB;
  localparam logic [15:0] EXP_FF = 16'h0FFF;
`endif

  typedef logic [NB-1:0][15:0] frame_t;
  typedef struct { frame_t exp; int acc; } sb_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  logic   s_valid = 1'b0;
  logic   s_ready;
  frame_t din = '0;
  logic   m_valid;
  logic   m_ready = 1'b0;
  frame_t dout;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  sb_t sbq[$];
  sb_t mon_item;
  logic mv_prev = 1'b0;

  mel_log_compress #(.NBANDS(NB), .IN_W(16), .FRAC_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .in(din), .m_valid(m_valid), .m_ready(m_ready), .out(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sc(input logic [15:0] v);
`ifdef MEL_LOG_DB_EN
    return 16'((32'(v) * 32'd771) >> 8);
`else
    return v;
`endif
  endfunction

  // Independent reference: integer log by repeated halving, mantissa by
  // arithmetic on the remainder below the leading power of two.
  function automatic logic [15:0] log2_ref(input int x);
    int p, v, frac;
    if (x == 0) return 16'h0000;
    p = 0; v = x;
    while (v > 1) begin v = v >> 1; p++; end
    frac = ((x - (1 << p)) << 8) >> p;
    return 16'((p << 8) | frac);
  endfunction

  // Scoreboard monitor: checks every frame when m_valid rises.
  always @(negedge clk) begin
    if (!reset_n) mv_prev <= 1'b0;
    else begin
      if (m_valid && !mv_prev) begin
        if (sbq.size() == 0) chk("spurious_mvalid", 32'd1, 32'd0);
        else begin
          mon_item = sbq.pop_front();
          chk("latency", cyc - mon_item.acc, LAT);
          for (int i = 0; i < NB; i++)
            chk($sformatf("out[%0d]", i), dout[i], mon_item.exp[i]);
        end
      end
      mv_prev <= m_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input frame_t d, input frame_t e);
    int  n;
    sb_t it;
    din = d; s_valid = 1'b1; n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      s_valid = 1'b0;
      return;
    end
    it.exp = e; it.acc = cyc + 1; sbq.push_back(it);
    @(negedge clk);
    s_valid = 1'b0;
    chk("s_ready_fall", s_ready, 0);
  endtask

  task automatic wait_mv();
    int n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    if (!m_valid) chk("mvalid_timeout", 32'd1, 32'd0);
  endtask

  frame_t f1_in, f1_exp, ff_in, ff_exp, ramp_in, ramp_exp, junk, snap;

  initial begin
    f1_in = '0; f1_exp = '0;
    f1_in[0] = 16'd0;    f1_exp[0] = 16'h0000;
    f1_in[1] = 16'd1;    f1_exp[1] = 16'h0000;
    f1_in[2] = 16'd2;    f1_exp[2] = 16'h0100;
    f1_in[3] = 16'd3;    f1_exp[3] = 16'h0180;
    f1_in[4] = 16'h0300; f1_exp[4] = 16'h0980;
    for (int i = 0; i < NB; i++) begin
      f1_exp[i] = sc(f1_exp[i]);
      ff_in[i]  = 16'hFFFF;
      ff_exp[i] = EXP_FF;
      ramp_in[i] = 16'(i + 1);
      ramp_exp[i] = log2_ref(i + 1);
      junk[i] = 16'h1234 + 16'(i);
    end
    ramp_exp[0] = 16'h0000; ramp_exp[1] = 16'h0100; ramp_exp[2] = 16'h0180;
    ramp_exp[7] = 16'h0300; ramp_exp[39] = 16'h0540;
    for (int i = 0; i < NB; i++) ramp_exp[i] = sc(ramp_exp[i]);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(dout == '0), 1);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_sready", s_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out", 32'(dout == '0), 1);
    chk("post_rst_sready", s_ready, 1);

    // Frame A with s_valid/in toggling while busy
    send(f1_in, f1_exp);
    for (int i = 0; i < 8; i++) begin
      s_valid = i[0]; din = junk;
      @(negedge clk);
      chk("busy_sready", s_ready, 0);
    end
    s_valid = 1'b0;
    wait_mv();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("A_sready_return", s_ready, 1);
    chk("A_mvalid_drop", m_valid, 0);

    // Frame B: all 0xFFFF with 20 cycles of backpressure
    m_ready = 1'b1;   // early m_ready: must not matter
    send(ff_in, ff_exp);
    m_ready = 1'b0;
    wait_mv();
    snap = dout;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_mvalid", m_valid, 1);
      chk("bp_sready", s_ready, 0);
      chk("bp_out_stable", 32'(dout == snap), 1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("B_sready_return", s_ready, 1);

    // Frame C aborted by reset mid-PROC
    send(ramp_in, ramp_exp);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_out", 32'(dout == '0), 1);
    chk("abort_mvalid", m_valid, 0);
    chk("abort_sready", s_ready, 1);
    sbq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Frame D then back-to-back ramp frame E
    send(f1_in, f1_exp);
    wait_mv();
    m_ready = 1'b1; din = ramp_in; s_valid = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("D_sready_return", s_ready, 1);
    chk("D_mvalid_drop", m_valid, 0);
    send(ramp_in, ramp_exp);
    wait_mv();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
